// File: rtl/dft_mac_core.sv
// Complex DFT multiply-accumulate engine.
// It runs the n/k loops itself. For each bin k it streams N sample/twiddle reads through a
// two-stage multiply/accumulate pipeline. The accumulated bin is then rounded, saturated and
// offered on a valid/ready result stream.
module dft_mac_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ACC_W  = 40
) (
  input  logic                  clk,
  input  logic                  n_Reset,
  input  logic                  i_start,
  input  logic                  i_inverse,
  input  logic [ADDR_W-1:0]     i_samp_number,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_smp_rd,
  output logic [ADDR_W-1:0]     o_smp_addr,
  input  logic [2*DATA_W-1:0]   i_smp_data,
  output logic                  o_tw_rd,
  output logic [ADDR_W-1:0]     o_tw_addr,
  input  logic [2*DATA_W-1:0]   i_tw_data,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [2*DATA_W-1:0]   o_res_data,
  output logic [ADDR_W-1:0]     o_res_k,
  output logic                  o_ovf
);

  localparam int unsigned PW = 2 * DATA_W + 1;
  localparam logic signed [ACC_W:0] RndBias = (ACC_W + 1)'(2 ** (DATA_W - 2));
  localparam logic signed [ACC_W:0] SatMax  = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W:0] SatMin  = ~SatMax;

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StOut, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        len_q, len_d;
  logic                     inv_q, inv_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic [ADDR_W-1:0]        n_q, n_d;
  logic [ADDR_W-1:0]        m_q, m_d;
  logic                     drain_q, drain_d;
  logic                     clr_acc, clr_ovf;
  logic [ADDR_W:0]          m_sum, m_sub, k_next;

  logic                     rd_q, p_vld_q, ovf_q;
  logic signed [PW-1:0]     p_re_q, p_im_q, prod_re, prod_im;
  logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
  logic signed [DATA_W-1:0] xr, xi, wr, wi;
  logic signed [PW-1:0]     e_rr, e_ii, e_ri, e_ir;
  logic [DATA_W:0]          rs_re, rs_im;

  // Round half up, arithmetic shift down to DATA_W, clamp. The MSB of the result flags a clamp.
  function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = $signed({a[ACC_W-1], a}) + RndBias;
    t = t >>> (DATA_W - 1);
    if (t > SatMax) begin
      round_sat = {1'b1, 1'b0, {(DATA_W - 1){1'b1}}};
    end else if (t < SatMin) begin
      round_sat = {1'b1, 1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      round_sat = {1'b0, t[DATA_W-1:0]};
    end
  endfunction

  // Full-precision complex product. The inverse transform conjugates the twiddle by flipping
  // the sign of the wi terms here, so no DATA_W negation is needed that could overflow.
  always_comb begin
    xr = i_smp_data[2*DATA_W-1:DATA_W];
    xi = i_smp_data[DATA_W-1:0];
    wr = i_tw_data[2*DATA_W-1:DATA_W];
    wi = i_tw_data[DATA_W-1:0];
    e_rr = PW'(xr) * PW'(wr);
    e_ii = PW'(xi) * PW'(wi);
    e_ri = PW'(xr) * PW'(wi);
    e_ir = PW'(xi) * PW'(wr);
    if (inv_q) begin
      prod_re = e_rr + e_ii;
      prod_im = e_ir - e_ri;
    end else begin
      prod_re = e_rr - e_ii;
      prod_im = e_ri + e_ir;
    end
  end

  // Rounded and saturated view of the accumulators.
  always_comb begin
    rs_re = round_sat(acc_re_q);
    rs_im = round_sat(acc_im_q);
  end

  // Next-state, loop counters and stream/strobe outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    inv_d       = inv_q;
    k_d         = k_q;
    n_d         = n_q;
    m_d         = m_q;
    drain_d     = drain_q;
    clr_acc     = 1'b0;
    clr_ovf     = 1'b0;
    o_busy      = (state_q != StIdle);
    o_done      = 1'b0;
    o_smp_rd    = 1'b0;
    o_tw_rd     = 1'b0;
    o_smp_addr  = '0;
    o_tw_addr   = '0;
    o_res_valid = 1'b0;
    o_res_k     = '0;
    o_res_data  = '0;
    m_sum       = {1'b0, m_q} + {1'b0, k_q};
    m_sub       = m_sum - {1'b0, len_q};
    k_next      = {1'b0, k_q} + (ADDR_W + 1)'(1);
    unique case (state_q)
      StIdle: begin
        if (i_start && (i_samp_number != '0)) begin
          len_d   = i_samp_number;
          inv_d   = i_inverse;
          k_d     = '0;
          n_d     = '0;
          m_d     = '0;
          clr_acc = 1'b1;
          clr_ovf = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        o_smp_rd   = 1'b1;
        o_tw_rd    = 1'b1;
        o_smp_addr = n_q;
        o_tw_addr  = m_q;
        n_d        = n_q + ADDR_W'(1);
        // m tracks (k*n) mod N incrementally; m+k < 2N so one subtraction suffices
        m_d        = (m_sum >= {1'b0, len_q}) ? m_sub[ADDR_W-1:0] : m_sum[ADDR_W-1:0];
        if (n_q == len_q - ADDR_W'(1)) begin
          drain_d = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = StOut;
        end
      end
      StOut: begin
        o_res_valid = 1'b1;
        o_res_k     = k_q;
        o_res_data  = {rs_re[DATA_W-1:0], rs_im[DATA_W-1:0]};
        if (i_res_ready) begin
          k_d     = k_next[ADDR_W-1:0];
          n_d     = '0;
          m_d     = '0;
          clr_acc = 1'b1;
          state_d = (k_next < {1'b0, len_q}) ? StRun : StDone;
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    o_ovf = ovf_q;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!n_Reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      inv_q   <= 1'b0;
      k_q     <= '0;
      n_q     <= '0;
      m_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      inv_q   <= inv_d;
      k_q     <= k_d;
      n_q     <= n_d;
      m_q     <= m_d;
      drain_q <= drain_d;
    end
  end

  // Datapath: product register, accumulators and sticky overflow.
  always_ff @(posedge clk) begin
    if (!n_Reset) begin
      rd_q     <= 1'b0;
      p_vld_q  <= 1'b0;
      p_re_q   <= '0;
      p_im_q   <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_q    <= o_smp_rd;
      p_vld_q <= rd_q;
      if (rd_q) begin
        p_re_q <= prod_re;
        p_im_q <= prod_im;
      end
      if (clr_acc) begin
        acc_re_q <= '0;
        acc_im_q <= '0;
      end else if (p_vld_q) begin
        acc_re_q <= acc_re_q + ACC_W'(p_re_q);
        acc_im_q <= acc_im_q + ACC_W'(p_im_q);
      end
      if (clr_ovf) begin
        ovf_q <= 1'b0;
      end else if ((state_q == StOut) && (rs_re[DATA_W] || rs_im[DATA_W])) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dft_mac_core.sv
// Testbench for dft_mac_core: directed transforms checked against a direct-sum DFT model.
module tb_dft_mac_core;

  logic        clk = 1'b0;
  logic        n_Reset;
  logic        i_start;
  logic        i_inverse;
  logic [11:0] i_samp_number;
  logic        o_busy, o_done, o_smp_rd, o_tw_rd, o_res_valid, o_ovf, i_res_ready;
  logic [11:0] o_smp_addr, o_tw_addr, o_res_k;
  logic [31:0] i_smp_data, i_tw_data, o_res_data;

  always #5 clk = ~clk;

  dft_mac_core #(.DATA_W(16), .ADDR_W(12), .ACC_W(40)) dut (
    .clk          (clk),
    .n_Reset      (n_Reset),
    .i_start      (i_start),
    .i_inverse    (i_inverse),
    .i_samp_number(i_samp_number),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_smp_rd     (o_smp_rd),
    .o_smp_addr   (o_smp_addr),
    .i_smp_data   (i_smp_data),
    .o_tw_rd      (o_tw_rd),
    .o_tw_addr    (o_tw_addr),
    .i_tw_data    (i_tw_data),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_data   (o_res_data),
    .o_res_k      (o_res_k),
    .o_ovf        (o_ovf)
  );

  typedef struct {int k; int re; int im;} res_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   xr_mem[16];
  int   xi_mem[16];
  int   cur_n = 1;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   tw_log[256];
  int   res_re[16];
  int   res_im[16];
  bit   exp_ovf;
  res_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tw_re(input int m, input int n);
    real a;
    a = 2.0 * 3.141592653589793 * real'(m) / real'(n);
    return int'($cos(a) * 32767.0);
  endfunction

  function automatic int tw_im(input int m, input int n);
    real a;
    a = 2.0 * 3.141592653589793 * real'(m) / real'(n);
    return int'(-$sin(a) * 32767.0);
  endfunction

  function automatic int rnd_sat(input longint a);
    longint t;
    t = (a + 16384) >>> 15;
    if (t > 32767) begin
      exp_ovf = 1'b1;
      return 32767;
    end
    if (t < -32768) begin
      exp_ovf = 1'b1;
      return -32768;
    end
    return int'(t);
  endfunction

  // Direct DFT sum X[k] = sum x[n] * W(k*n mod N), conjugated twiddle for inverse.
  function automatic void build_model(input int n, input bit inv);
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < n; k++) begin
      longint ar, ai, wr, wi;
      res_t r;
      ar = 0;
      ai = 0;
      for (int j = 0; j < n; j++) begin
        wr = tw_re((k * j) % n, n);
        wi = tw_im((k * j) % n, n);
        if (inv) wi = -wi;
        ar += xr_mem[j] * wr - xi_mem[j] * wi;
        ai += xr_mem[j] * wi + xi_mem[j] * wr;
      end
      r.k  = k;
      r.re = rnd_sat(ar);
      r.im = rnd_sat(ai);
      exp_q.push_back(r);
    end
  endfunction

  // Sample RAM and twiddle ROM, one cycle read latency.
  always @(posedge clk) begin
    if (o_smp_rd) i_smp_data <= {16'(xr_mem[o_smp_addr[3:0]]), 16'(xi_mem[o_smp_addr[3:0]])};
    if (o_tw_rd) begin
      i_tw_data <= {16'(tw_re(int'(o_tw_addr), cur_n)), 16'(tw_im(int'(o_tw_addr), cur_n))};
    end
  end

  // Compare process: read addresses and result stream against the model every cycle.
  always @(negedge clk) begin
    int ne, ke;
    if (n_Reset === 1'b1) begin
      if (o_smp_rd) begin
        ne = rd_cnt % cur_n;
        ke = rd_cnt / cur_n;
        chk("smp_addr", o_smp_addr, ne);
        chk("tw_addr", o_tw_addr, (ke * ne) % cur_n);
        chk("tw_rd", o_tw_rd, 1);
        if (rd_cnt < 256) tw_log[rd_cnt] = int'(o_tw_addr);
        rd_cnt++;
      end
      if (o_res_valid) begin
        chk("strobes_in_out", {o_smp_rd, o_tw_rd}, 0);
        chk("res_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("res_k", o_res_k, exp_q[0].k);
          chk("res_re", $signed(o_res_data[31:16]), exp_q[0].re);
          chk("res_im", $signed(o_res_data[15:0]), exp_q[0].im);
          if (i_res_ready) begin
            res_re[exp_q[0].k] = $signed(o_res_data[31:16]);
            res_im[exp_q[0].k] = $signed(o_res_data[15:0]);
            void'(exp_q.pop_front());
          end
        end
      end
      if (o_done) begin
        done_cnt++;
        chk("done_pending_results", exp_q.size(), 0);
      end
    end
  end

  task automatic clear_x();
    for (int i = 0; i < 16; i++) begin
      xr_mem[i] = 0;
      xi_mem[i] = 0;
      res_re[i] = 99999;
      res_im[i] = 99999;
    end
  endtask

  task automatic run(input int n, input bit inv, input int stall_k, input int stall_len,
                     input bit glitch);
    int t0, lat, stalled;
    cur_n  = n;
    rd_cnt = 0;
    build_model(n, inv);
    @(posedge clk); #1;
    i_samp_number = 12'(n);
    i_inverse     = inv;
    i_start       = 1'b1;
    t0            = cyc;
    @(posedge clk); #1;
    i_start   = 1'b0;
    i_inverse = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("ovf_cleared_at_start", o_ovf, 0);
    lat     = -1;
    stalled = 0;
    for (int c = 1; c < 3000 && lat < 0; c++) begin
      if (o_done) lat = cyc - t0;
      if (glitch && c == 3) begin
        i_start       = 1'b1;
        i_samp_number = 12'd2;
      end else begin
        i_start = 1'b0;
      end
      if (o_res_valid && int'(o_res_k) == stall_k && stalled < stall_len) begin
        i_res_ready = 1'b0;
        stalled++;
      end else begin
        i_res_ready = 1'b1;
      end
      if (lat < 0) begin
        @(posedge clk); #1;
      end
    end
    i_res_ready = 1'b1;
    i_start     = 1'b0;
    chk("done_latency", lat, 1 + n * (n + 3) + stall_len);
    chk("read_count", rd_cnt, n * n);
    @(posedge clk); #1;
    chk("idle_after_done", {o_busy, o_done}, 0);
    chk("ovf_after_run", o_ovf, exp_ovf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    n_Reset       = 1'b0;
    i_start       = 1'b0;
    i_inverse     = 1'b0;
    i_samp_number = '0;
    i_res_ready   = 1'b1;
    clear_x();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", {o_busy, o_done, o_smp_rd, o_smp_addr, o_tw_rd, o_tw_addr,
                                o_res_valid, o_res_data, o_res_k, o_ovf} != '0, 0);
    n_Reset = 1'b1;

    // Zero-length start is ignored.
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("zero_len_start_ignored", o_busy, 0);

    // Impulse.
    clear_x();
    xr_mem[0] = 1000;
    run(4, 1'b0, -1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("impulse_re", res_re[k], 1000);
      chk("impulse_im", res_im[k], 0);
    end

    // DC, with a start pulse during RUN that must be ignored.
    clear_x();
    for (int i = 0; i < 4; i++) xr_mem[i] = 8000;
    run(4, 1'b0, -1, 0, 1'b1);
    chk("dc_X0_re", res_re[0], 31999);
    chk("dc_X0_im", res_im[0], 0);
    chk("dc_X2_re", res_re[2], 0);
    chk("dc_X3_im", res_im[3], 0);
    for (int i = 0; i < 4; i++) chk("dc_tw_seq_k1", tw_log[4 + i], i);
    for (int i = 0; i < 4; i++) chk("dc_tw_seq_k2", tw_log[8 + i], (i % 2) * 2);

    // Forward vs inverse of a delayed impulse.
    clear_x();
    xr_mem[1] = 1000;
    run(4, 1'b0, -1, 0, 1'b0);
    chk("fwd_X1_re", res_re[1], 0);
    chk("fwd_X1_im", res_im[1], -1000);
    run(4, 1'b1, -1, 0, 1'b0);
    chk("inv_X1_re", res_re[1], 0);
    chk("inv_X1_im", res_im[1], 1000);

    // Saturation, then a small run that must clear the sticky flag.
    clear_x();
    for (int i = 0; i < 8; i++) xr_mem[i] = 20000;
    run(8, 1'b0, -1, 0, 1'b0);
    chk("sat_X0_re", res_re[0], 32767);
    chk("sat_X0_im", res_im[0], 0);
    chk("sat_ovf_sticky", o_ovf, 1);

    // Backpressure on bin 2 for five cycles.
    clear_x();
    xr_mem[0] = 1000;
    run(4, 1'b0, 2, 5, 1'b0);
    chk("bp_X2_re", res_re[2], 1000);
    chk("bp_ovf_cleared", o_ovf, 0);

    // Reset in the middle of bin 1.
    clear_x();
    xr_mem[0] = 1000;
    cur_n  = 4;
    rd_cnt = 0;
    build_model(4, 1'b0);
    @(posedge clk); #1;
    i_samp_number = 12'd4;
    i_start       = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_reading_bin1", rd_cnt / 4, 1);
    n_Reset = 1'b0;
    @(posedge clk); #1;
    chk("midrun_reset_outputs_zero", {o_busy, o_done, o_smp_rd, o_smp_addr, o_tw_rd, o_tw_addr,
                                       o_res_valid, o_res_data, o_res_k, o_ovf} != '0, 0);
    exp_q.delete();
    dc      = done_cnt;
    n_Reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - dc, 0);

    // Single-point transform.
    clear_x();
    xr_mem[0] = -500;
    xi_mem[0] = 300;
    run(1, 1'b0, -1, 0, 1'b0);
    chk("n1_X0_re", res_re[0], -500);
    chk("n1_X0_im", res_im[0], 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dft_mac_core.md
Name: dft_mac_core

Overview:
Parametrised complex DFT multiply-accumulate engine and the successor to the fixed 16-bit real-input compute path. It supports complex input samples, forward and inverse transforms, and configurable data, address and accumulator widths. Results leave on a valid/ready stream with backpressure. It sits between the sample RAM, the twiddle ROM and the AXI bridge result path, and it sequences its own n/k loops under a start/done handshake.

Parameters:
DATA_W, 16, width of each real/imag component of samples, twiddles and results (signed, twiddles Q1.(DATA_W-1))
ADDR_W, 12, sample/bin index width; max N = 2^ADDR_W-1
ACC_W, 40, signed accumulator width per component; must be >= 2*DATA_W+1

Ports:
clk  in  1  clock, all logic rising-edge
n_Reset  in  1  synchronous active-low reset
i_start  in  1  start request, sampled in IDLE only
i_inverse  in  1  1 = inverse (conjugated twiddle), latched at start
i_samp_number  in  ADDR_W  transform length N, latched at start
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse after last bin handshake
o_smp_rd  out  1  sample read strobe
o_smp_addr  out  ADDR_W  sample index n
i_smp_data  in  2*DATA_W  {re,im} of x[n], valid 1 cycle after o_smp_rd
o_tw_rd  out  1  twiddle read strobe
o_tw_addr  out  ADDR_W  m = (k*n) mod N
i_tw_data  in  2*DATA_W  {cos,-sin}(2*pi*m/N), valid 1 cycle after o_tw_rd
o_res_valid  out  1  result valid
i_res_ready  in  1  result accept
o_res_data  out  2*DATA_W  {re,im} of X[k], rounded and saturated
o_res_k  out  ADDR_W  bin index of o_res_data
o_ovf  out  1  sticky saturation flag, cleared at start

Behaviour:
- Reset (n_Reset=0 at an edge): state IDLE. All outputs 0. Counters, accumulators, latched N/mode and o_ovf are cleared. Reset during any state aborts the transform, and no o_done is issued.
- FSM: IDLE -> RUN -> DRAIN -> OUT -> (RUN for next k | DONE) ; DONE -> IDLE.
- IDLE: i_start=1 with i_samp_number!=0 latches N and i_inverse, clears k, n, m, accumulators and o_ovf, then goes to RUN. If i_samp_number==0, the start is ignored. i_start is ignored outside IDLE.
- RUN, exactly N cycles: o_smp_rd=o_tw_rd=1, o_smp_addr=n, o_tw_addr=m. Each cycle n++ and m+=k, with m-=N if m>=N; m uses ADDR_W+1 bits internally, so no multiplier. After n=N-1, go to DRAIN.
- Pipeline: stage1 (addr+1 cycle) registers the complex product p = x*w. Stage2 adds p into the accumulator. When inverse, w.im is negated before the multiply. re=xr*wr-xi*wi and im=xr*wi+xi*wr, both full precision, sign-extended to ACC_W.
- DRAIN: 2 cycles, strobes low. This flushes the pipeline, then go to OUT.
- OUT: o_res_valid=1 and o_res_k=k. Each component is computed as (acc + 2^(DATA_W-2)) >>> (DATA_W-1), i.e. round half up, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any saturation sets o_ovf.
- OUT handshake: o_res_data and o_res_k are held stable while i_res_ready=0, and no reads are issued. On valid&ready: k++, n=m=0, accumulators are cleared. Go to RUN if k<N, otherwise go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_ovf holds until the next accepted start.
- No 1/N scaling on inverse.
- Latency with ready high: N+3 cycles per bin. For start sampled at cycle 0, o_done is high in cycle 1+N*(N+3).
- N=1: a single bin, X[0]=x[0]*W^0.

Test Plan:
1. Impulse: N=4, x[0]=(1000,0), others 0, twiddle ROM with 32767 scaling, ready tied 1 -> X[0..3]=(1000,0), o_res_k=0,1,2,3, o_done in cycle 29, o_ovf=0.
2. DC: N=4, all x=(8000,0) -> X[0]=(31999,0) and X[1..3]=(0,0) within ±1 LSB. Each RUN shows o_tw_addr sequences k=1:0,1,2,3 and k=2:0,2,0,2.
3. Inverse mode: N=4, x[1]=(1000,0). With i_inverse=0, X[1]≈(0,-1000). Rerun with i_inverse=1 -> X[1]≈(0,+1000), ±1 LSB.
4. Saturation: N=8, all x=(20000,0) -> X[0]=(32767,0) and o_ovf=1 after bin 0, holding until the next start. A following start with small data clears o_ovf.
5. Backpressure: hold i_res_ready=0 for 5 cycles at k=2 -> o_res_data and o_res_k stay constant, strobes stay 0, and o_done is delayed by exactly 5 cycles.
6. Control corners: i_start pulsed mid-RUN -> ignored. n_Reset=0 during RUN for k=1 -> all outputs 0 on the next cycle, no o_done, and a subsequent start with N=1, x[0]=(-500,300) yields X[0]=(-500,300).
